// File: rtl/facto_pkg.sv
// Shared FSM state type and default widths for the factorial core and its multiplier.
package facto_pkg;

    localparam int OPER_W_DEF = 64;
    localparam int RES_W_DEF  = 128;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_MUL,
        ST_STEP,
        ST_DONE
    } facto_state_e;

endpackage

// File: rtl/facto_mul.sv
// Iterative shift-add multiplier, one multiplier bit per cycle (OPER_W cycles per product).
// With FACTO_CORE_OVF_DETECT_EN the product keeps RES_W+OPER_W bits, otherwise RES_W bits.
module facto_mul
    import facto_pkg::*;
#(
    parameter int OPER_W = OPER_W_DEF,
    parameter int RES_W  = RES_W_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    clear,
    input  logic [RES_W-1:0]        mcand,
    input  logic [OPER_W-1:0]       mplier,
    output logic                    done,
`ifdef FACTO_CORE_OVF_DETECT_EN
    output logic [RES_W+OPER_W-1:0] product
`else
    output logic [RES_W-1:0]        product
`endif
);

`ifdef FACTO_CORE_OVF_DETECT_EN
    localparam int PROD_W = RES_W + OPER_W;
`else
    localparam int PROD_W = RES_W;
`endif
    localparam int CNT_W = $clog2(OPER_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(OPER_W - 1);

    logic [PROD_W-1:0] mcand_q, mcand_d;
    logic [PROD_W-1:0] prod_q, prod_d;
    logic [OPER_W-1:0] mplier_q, mplier_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              run_q, run_d;

    always_comb begin
        mcand_d  = mcand_q;
        prod_d   = prod_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        run_d    = run_q;
        if (clear) begin
            mcand_d  = '0;
            prod_d   = '0;
            mplier_d = '0;
            cnt_d    = '0;
            run_d    = 1'b0;
        end else if (start) begin
            mcand_d  = PROD_W'(mcand);
            prod_d   = '0;
            mplier_d = mplier;
            cnt_d    = '0;
            run_d    = 1'b1;
        end else if (run_q) begin
            if (mplier_q[0]) begin
                prod_d = prod_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == LAST_BIT) begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_q  <= '0;
            prod_q   <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            prod_q   <= prod_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            run_q    <= run_d;
        end
    end

    // High while the final bit is being accumulated; product is complete on the next cycle.
    assign done    = run_q && (cnt_q == LAST_BIT);
    assign product = prod_q;

endmodule

// File: rtl/facto_core_p.sv
// Factorial core: n! of a signed operand by repeated multiplication through facto_mul.
// Define FACTO_CORE_OVF_DETECT_EN to widen the product and report overflow on op_ovf.
module facto_core_p
    import facto_pkg::*;
#(
    parameter int OPER_W = OPER_W_DEF,
    parameter int RES_W  = RES_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_start,
    input  logic              op_clear,
    input  logic [OPER_W-1:0] oper,
    output logic              op_busy,
    output logic              op_done,
    output logic              op_err,
    output logic              op_ovf,
    output logic [RES_W-1:0]  result
);

`ifdef FACTO_CORE_OVF_DETECT_EN
    localparam int PROD_W = RES_W + OPER_W;
`else
    localparam int PROD_W = RES_W;
`endif
    localparam logic signed [OPER_W-1:0] K_ONE   = OPER_W'(1);
    localparam logic signed [OPER_W-1:0] K_TWO   = OPER_W'(2);
    localparam logic [RES_W-1:0]         ACC_ONE = RES_W'(1);

    facto_state_e               state_q, state_d;
    logic signed [OPER_W-1:0]   k_q, k_d;
    logic [RES_W-1:0]           acc_q, acc_d;
    logic                       err_q, err_d;
    logic                       mul_start, mul_done;
    logic [PROD_W-1:0]          mul_product;
`ifdef FACTO_CORE_OVF_DETECT_EN
    logic                       ovf_q, ovf_d;
`endif

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        acc_d     = acc_q;
        err_d     = err_q;
        mul_start = 1'b0;
`ifdef FACTO_CORE_OVF_DETECT_EN
        ovf_d     = ovf_q;
`endif
        if (op_clear) begin
            state_d = ST_IDLE;
            k_d     = '0;
            acc_d   = '0;
            err_d   = 1'b0;
`ifdef FACTO_CORE_OVF_DETECT_EN
            ovf_d   = 1'b0;
`endif
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (op_start) begin
                        state_d = ST_CHECK;
                        k_d     = oper;
                        acc_d   = ACC_ONE;
                        err_d   = 1'b0;
`ifdef FACTO_CORE_OVF_DETECT_EN
                        ovf_d   = 1'b0;
`endif
                    end
                end
                ST_CHECK: begin
                    if (k_q[OPER_W-1]) begin
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                        acc_d   = '0;
                    end else if (k_q <= K_ONE) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d   = ST_MUL;
                        mul_start = 1'b1;
                    end
                end
                ST_MUL: begin
                    if (mul_done) begin
                        state_d = ST_STEP;
                    end
                end
                ST_STEP: begin
                    acc_d = mul_product[RES_W-1:0];
`ifdef FACTO_CORE_OVF_DETECT_EN
                    ovf_d = ovf_q | (|mul_product[PROD_W-1:RES_W]);
`endif
                    k_d   = k_q - K_ONE;
                    if (k_q == K_TWO) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d   = ST_MUL;
                        mul_start = 1'b1;
                    end
                end
                ST_DONE: begin
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            acc_q   <= '0;
            err_q   <= 1'b0;
`ifdef FACTO_CORE_OVF_DETECT_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            err_q   <= err_d;
`ifdef FACTO_CORE_OVF_DETECT_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    // The next-state acc/k feed the multiplier so a restart from STEP uses the updated pair.
    facto_mul #(
        .OPER_W (OPER_W),
        .RES_W  (RES_W)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .clear   (op_clear),
        .mcand   (acc_d),
        .mplier  (k_d),
        .done    (mul_done),
        .product (mul_product)
    );

    assign op_done = (state_q == ST_DONE);
    assign op_busy = (state_q == ST_CHECK) || (state_q == ST_MUL) || (state_q == ST_STEP);
    assign op_err  = op_done && err_q;
`ifdef FACTO_CORE_OVF_DETECT_EN
    assign op_ovf  = op_done && ovf_q;
`else
    assign op_ovf  = 1'b0;
`endif
    assign result  = op_done ? acc_q : '0;

endmodule

// File: doc/facto_core_p.md
FACTO_CORE_P -- requirements
Module: facto_core_p

Interface
REQ-001 Parameter OPER_W, default 64, operand width in bits (signed two's complement), legal range 4..64.
REQ-002 Parameter RES_W, default 128, result width in bits, SHALL be >= OPER_W.
REQ-003 clk  input  1  single clock; all logic SHALL be rising-edge triggered.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 op_start  input  1  start request, level; sampled only in IDLE.
REQ-006 op_clear  input  1  abort/acknowledge, level; returns block to IDLE.
REQ-007 oper  input  OPER_W  signed operand n.
REQ-008 op_busy  output  1  high while a computation is in progress.
REQ-009 op_done  output  1  high from completion until op_clear or reset.
REQ-010 op_err  output  1  high with op_done when oper was negative.
REQ-011 op_ovf  output  1  high with op_done when the true n! exceeded RES_W bits.
REQ-012 result  output  RES_W  unsigned n!, valid while op_done=1.

Function
REQ-013 FSM states: IDLE, CHECK, MUL, STEP, DONE.
REQ-014 IDLE: op_start=1 and op_clear=0 SHALL capture oper into an internal counter k, set acc=1, go to CHECK.
REQ-015 CHECK (1 cycle): oper<0 -> DONE with op_err=1 and result=0; oper in {0,1} -> DONE with result=1; else -> MUL.
REQ-016 MUL: SHALL start facto_mul with acc and k, then remain in MUL for exactly OPER_W cycles (one shift-add bit per cycle).
REQ-017 STEP (1 cycle): acc takes the low RES_W bits of the product; k decrements; k==2 before the decrement -> DONE, else -> MUL.
REQ-018 Latency from the op_start sample edge to op_done=1: 2 cycles for n<=1 or n<0; 2+(n-1)*(OPER_W+1) cycles for n>=2.
REQ-019 DONE: op_done=1, op_busy=0, result=acc; result and flags SHALL hold until op_clear.
REQ-020 op_start while in CHECK, MUL, STEP or DONE SHALL be ignored; a held op_start SHALL NOT retrigger until DONE has been cleared and op_start is sampled again in IDLE.
REQ-021 op_clear=1 in any state SHALL go to IDLE on the next edge, abort any multiply, and zero result, op_done, op_err and op_ovf.
REQ-022 op_start and op_clear both high in IDLE: op_clear SHALL win and no operation SHALL start.
REQ-023 oper changes after capture SHALL NOT affect the running computation.
REQ-024 op_busy SHALL be 1 exactly in CHECK, MUL and STEP.

Reset
REQ-025 reset=1 SHALL force IDLE on the next edge, from any state including mid-MUL.
REQ-026 Reset values: op_busy=0, op_done=0, op_err=0, op_ovf=0, result=0; internal acc, k and multiplier registers SHALL be 0.
REQ-027 reset SHALL take priority over op_clear and op_start.

Configuration
REQ-028 Macro FACTO_CORE_OVF_DETECT_EN defined: facto_mul SHALL produce the full RES_W+OPER_W product; in STEP any nonzero bit above RES_W-1 SHALL set a sticky overflow bit, reported as op_ovf in DONE; result SHALL still be the truncated low RES_W bits.
REQ-029 Macro not defined: product SHALL be computed to RES_W bits only, and op_ovf SHALL be tied to 0.

Structure
REQ-030 Shared package facto_pkg SHALL hold the FSM state enum and the defaults OPER_W_DEF=64 and RES_W_DEF=128.
REQ-031 Sub-module facto_mul: iterative shift-add multiplier with start, done and clear inputs, parametrised by OPER_W and RES_W; the FSM SHALL be in facto_core_p.

Verification
REQ-032 Defaults; oper=7, op_start held high -> op_done=1 after 392 cycles, result=5040, op_err=0, op_ovf=0; op_clear -> all outputs 0 on the next cycle.
REQ-033 oper=0, then oper=1 -> each run: op_done after 2 cycles, result=1.
REQ-034 oper=-3 -> op_done after 2 cycles, op_err=1, result=0.
REQ-035 OPER_W=8, RES_W=16; oper=9 -> result=0x8980 (362880 mod 65536) with op_ovf=1 when the macro is defined, op_ovf=0 when it is not; oper=8 -> result=40320, op_ovf=0.
REQ-036 oper=5; assert reset, then in a later run op_clear, at cycle 20 mid-MUL -> IDLE and all outputs 0 on the next cycle; a new oper=4 run -> result=24.
REQ-037 op_start and op_clear both high in IDLE -> op_busy stays 0; a toggle of oper during a run of oper=6 -> result=720.
